// File: rtl/fifo2udp_tx_if.sv
// Handshake bundle between the frame controller, the payload FIFO and the UDP TX engine.
// The master modport is the fifo2udp_tx side; the slave modport is its environment.
interface fifo2udp_tx_if;
    logic        fs;
    logic        fd;
    logic [11:0] data_len;
    logic        fifod_rxen;
    logic [7:0]  fifod_rxd;
    logic        fifod_empty;
    logic        flag_udp_tx_req;
    logic        flag_udp_tx_prep;
    logic        udp_txen;
    logic [7:0]  udp_txd;
    logic        err;

    modport master (
        input  fs, data_len, fifod_rxd, fifod_empty, flag_udp_tx_prep,
        output fd, fifod_rxen, flag_udp_tx_req, udp_txen, udp_txd, err
    );

    modport slave (
        output fs, data_len, fifod_rxd, fifod_empty, flag_udp_tx_prep,
        input  fd, fifod_rxen, flag_udp_tx_req, udp_txen, udp_txd, err
    );
endinterface

// File: rtl/fifo2udp_tx.sv
// Streams data_len bytes from a FIFO into a UDP TX engine once per frame-start handshake.
// Optional underflow / zero-length checking is enabled by defining FIFO2UDP_TX_CHECK_EN.
module fifo2udp_tx (
    input  logic          clk,
    input  logic          rst,
    fifo2udp_tx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_READ = 3'd2,
        S_LAST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [11:0] cnt_q, cnt_d;
    logic        fd_q, rxen_q, req_q, txen_q, prep_q;

    // Next-state, length latch and read counter.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fs) begin
                    len_d   = bus.data_len;
                    cnt_d   = 12'd0;
                    state_d = (bus.data_len != 12'd0) ? S_REQ : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (prep_q) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_d == len_q) begin
                    state_d = S_LAST;
                end else begin
                    state_d = S_READ;
                end
            end
            S_LAST: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.fs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they leave flops directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= 12'd0;
            cnt_q   <= 12'd0;
            fd_q    <= 1'b0;
            rxen_q  <= 1'b0;
            req_q   <= 1'b0;
            txen_q  <= 1'b0;
            prep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fd_q    <= (state_d == S_DONE);
            rxen_q  <= (state_d == S_READ);
            req_q   <= (state_d == S_REQ);
            txen_q  <= rxen_q;
            prep_q  <= bus.flag_udp_tx_prep;
        end
    end

    assign bus.fd              = fd_q;
    assign bus.fifod_rxen      = rxen_q;
    assign bus.flag_udp_tx_req = req_q;
    assign bus.udp_txen        = txen_q;
    // FIFO read data arrives the cycle after rxen, exactly when txen is high.
    assign bus.udp_txd         = txen_q ? bus.fifod_rxd : 8'h00;

`ifdef FIFO2UDP_TX_CHECK_EN
    logic err_q, err_d;

    // Sticky error: reloaded on each accepted frame start, set by reading an empty FIFO.
    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && bus.fs) begin
            err_d = (bus.data_len == 12'd0);
        end else if (rxen_q && bus.fifod_empty) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/fifo2udp_tx.md
FIFO2UDP_TX -- requirements
Module: fifo2udp_tx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have: fs  in  1  frame start from controlling FSM; level, held until fd seen.
REQ-004 SHALL have: fd  out  1  frame done; level, high in DONE only.
REQ-005 SHALL have: data_len  in  12  payload byte count; sampled on fs acceptance.
REQ-006 SHALL have: fifod_rxen  out  1  FIFO read enable; read data valid one clk later.
REQ-007 SHALL have: fifod_rxd  in  8  FIFO read data.
REQ-008 SHALL have: fifod_empty  in  1  FIFO empty flag.
REQ-009 SHALL have: flag_udp_tx_req  out  1  request to UDP TX engine to open a packet.
REQ-010 SHALL have: flag_udp_tx_prep  in  1  UDP TX engine ready for payload; level.
REQ-011 SHALL have: udp_txen  out  1  payload byte strobe to UDP TX engine.
REQ-012 SHALL have: udp_txd  out  8  payload byte, valid while udp_txen high.
REQ-013 SHALL have: err  out  1  sticky underflow/length error (see Configuration).

Function
REQ-014 SHALL implement states IDLE, REQ, READ, LAST, DONE.
REQ-015 IDLE: on fs=1 SHALL latch data_len into len_r, clear byte counter; go REQ if data_len!=0, else DONE.
REQ-016 REQ: SHALL drive flag_udp_tx_req=1; stay until flag_udp_tx_prep=1, then go READ on next edge; req drops on leaving REQ.
REQ-017 READ: SHALL drive fifod_rxen=1 every cycle for exactly len_r cycles; 12-bit counter increments per read; on read number len_r go LAST.
REQ-018 udp_txen SHALL equal fifod_rxen delayed one clk; udp_txd SHALL be fifod_rxd passed combinationally during that cycle.
REQ-019 LAST: one cycle, fifod_rxen=0, udp_txen=1 for final byte; then DONE.
REQ-020 DONE: fd=1; SHALL return to IDLE when fs=0; no new frame accepted while fs stays high.
REQ-021 udp_txen SHALL be high for exactly len_r contiguous cycles per frame, first asserted 2 clks after prep sampled high in REQ.
REQ-022 fs deassertion before DONE SHALL be ignored; frame always completes.
REQ-023 flag_udp_tx_prep changes outside REQ SHALL be ignored.
REQ-024 data_len changes after acceptance SHALL not affect the current frame; max len 4095, no wrap.
REQ-025 Block SHALL not stall on fifod_empty; producer guarantees len_r bytes present before fs.

Reset
REQ-026 rst=1 SHALL force state IDLE, counter 0, len_r 0, and fd, fifod_rxen, flag_udp_tx_req, udp_txen, err=0, udp_txd=0 asynchronously.
REQ-027 rst mid-frame SHALL abort with no further reads or strobes; next frame needs new fs after rst release.

Configuration
REQ-028 Macro FIFO2UDP_TX_CHECK_EN defined: err set (sticky) when fifod_rxen=1 while fifod_empty=1, or fs accepted with data_len=0; err cleared only by rst or next accepted fs.
REQ-029 Macro FIFO2UDP_TX_CHECK_EN undefined: err tied 0, no check logic; all other behaviour identical.

Verification
REQ-030 FIFO preloaded 0x01..0x0C, data_len=12, fs=1, prep 3 clks after req -> 12 txen cycles carrying 0x01..0x0C in order, fd=1, return IDLE after fs=0.
REQ-031 data_len=1, prep already high -> req 1 clk, one rxen, one txen byte, fd.
REQ-032 data_len=0 -> no req, no rxen/txen, fd next clk; err=1 with macro, 0 without.
REQ-033 rst pulsed on 5th READ cycle of 12-byte frame -> all outputs 0 same cycle, no further txen; new fs runs cleanly.
REQ-034 With macro, FIFO holds 4 bytes, data_len=6 -> err=1 at 5th read, stays 1 until next fs; frame still completes 6 txen.
REQ-035 fs dropped during READ -> frame completes; fd asserted, immediately IDLE since fs=0.
